// File: rtl/usart_rx.sv
// 8N1 serial receiver (LSB first, idle high) with start-glitch rejection,
// mid-bit sampling, framing/overrun detection and a valid/ready byte output.
`timescale 1ns/1ps

module usart_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);
  localparam logic [15:0] HALF_LAST  = 16'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [15:0] r_cycle_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_overrun;

  logic w_rx_s;
  logic w_fall;

  assign w_rx_s = r_sync2;
  assign w_fall = r_prev & ~r_sync2;

  assign rx_data       = r_data;
  assign rx_data_valid = r_valid;
  assign rx_frame_err  = r_frame_err;
  assign rx_overrun    = r_overrun;

  // NOTE: all state here updates with non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_prev      <= 1'b1;
      r_state     <= S_IDLE;
      r_cycle_cnt <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1     <= rx_pin;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_cycle_cnt <= r_cycle_cnt + 16'd1;

      if (r_state != S_DATA) r_bit_cnt <= '0;

      // An accept clears valid unless a new byte is loaded in the same cycle.
      if (r_valid && rx_data_ready) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state     <= S_START;
            r_cycle_cnt <= '0;
          end
        end

        S_START: begin
          if (r_cycle_cnt == HALF_LAST) begin
            r_cycle_cnt <= '0;
            r_state     <= w_rx_s ? S_IDLE : S_DATA;
          end
        end

        S_DATA: begin
          if (r_cycle_cnt == CYCLE_LAST) begin
            r_cycle_cnt        <= '0;
            r_shift[r_bit_cnt] <= w_rx_s;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
          end
        end

        S_STOP: begin
          if (r_cycle_cnt == CYCLE_LAST) begin
            r_cycle_cnt <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
              if (!r_valid || rx_data_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end
        end

        // Hold off until the line returns high so a break cannot retrigger.
        S_BREAK: begin
          if (w_rx_s) begin
            r_state     <= S_IDLE;
            r_cycle_cnt <= '0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cycle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_rx.sv
// Scoreboard bench for usart_rx: frames are generated from the 8N1 rules,
// expected bytes are queued at issue time and popped by a handshake monitor.
`timescale 1ns/1ps

module tb_usart_rx;

  localparam int CLK_FRE   = 50;
  localparam int BAUD_RATE = 115200;
  localparam int CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF      = CYCLE / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int fe_seen  = 0;
  int ov_seen  = 0;
  int fe_exp   = 0;
  int ov_exp   = 0;
  logic [7:0] exp_q[$];
  logic prev_fe = 1'b0;
  logic prev_ov = 1'b0;

  int lat;
  bit got;
  bit rand_done;

  always #10 clk = ~clk;

  usart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun)
  );

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected byte per accepted handshake; tracks pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_data_valid && rx_data_ready) begin
        check(exp_q.size() != 0, "unexpected_byte", rx_data, 0);
        if (exp_q.size() != 0) begin
          check(rx_data == exp_q[0], "rx_byte", rx_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (rx_frame_err) begin
        fe_seen++;
        check(!prev_fe, "frame_err_width", 2, 1);
        check(!rx_overrun, "err_ov_same_cycle", 1, 0);
      end
      if (rx_overrun) begin
        ov_seen++;
        check(!prev_ov, "overrun_width", 2, 1);
      end
    end
    prev_fe <= rx_frame_err;
    prev_ov <= rx_overrun;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int period, input bit stop_ok);
    rx_pin = 1'b0;
    repeat (period) tick();
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (period) tick();
    end
    rx_pin = stop_ok;
    repeat (period) tick();
    rx_pin = 1'b1;
  endtask

  // Reference model for a frame sent while the output register is free.
  task automatic issue(input logic [7:0] b, input int period, input bit stop_ok);
    if (stop_ok) exp_q.push_back(b);
    else         fe_exp++;
    send_frame(b, period, stop_ok);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(exp_q.size() == 0, name, exp_q.size(), 0);
  endtask

  task automatic check_counts(input string name);
    check(fe_seen == fe_exp, {name, "_frame_err_count"}, fe_seen, fe_exp);
    check(ov_seen == ov_exp, {name, "_overrun_count"}, ov_seen, ov_exp);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] b;
    bit         ok;
    int         period;
    int         gap;

    rst           = 1'b1;
    rx_pin        = 1'b1;
    rx_data_ready = 1'b0;
    repeat (5) tick();
    check(rx_data == 8'h00, "reset_data", rx_data, 0);
    check(rx_data_valid == 1'b0, "reset_valid", rx_data_valid, 0);
    check(rx_frame_err == 1'b0, "reset_frame_err", rx_frame_err, 0);
    check(rx_overrun == 1'b0, "reset_overrun", rx_overrun, 0);
    rst = 1'b0;
    repeat (10) tick();

    // Single byte with ready low: latency, hold, then a one-cycle accept.
    fork
      issue(8'hA5, CYCLE, 1'b1);
      begin
        lat = 0;
        got = 1'b0;
        while (!got && lat < 6000) begin
          tick();
          lat++;
          if (rx_data_valid) got = 1'b1;
        end
      end
    join
    check(got, "a5_valid_seen", got, 1);
    check(lat >= 2 + HALF + 9 * CYCLE + 1 - 4 && lat <= 2 + HALF + 9 * CYCLE + 1 + 4,
          "a5_latency", lat, 2 + HALF + 9 * CYCLE + 1);
    check(rx_data == 8'hA5, "a5_data_held", rx_data, 8'hA5);
    check(rx_data_valid == 1'b1, "a5_valid_held", rx_data_valid, 1);
    rx_data_ready = 1'b1;
    tick();
    rx_data_ready = 1'b0;
    check(rx_data_valid == 1'b0, "a5_valid_clear", rx_data_valid, 0);
    check_counts("a5");

    // Back-to-back frames with no idle gap.
    rx_data_ready = 1'b1;
    issue(8'h00, CYCLE, 1'b1);
    issue(8'hFF, CYCLE, 1'b1);
    issue(8'h55, CYCLE, 1'b1);
    wait_drain(2 * CYCLE, "b2b_drain");
    check_counts("b2b");

    // Short low glitch must not start a reception.
    rx_pin = 1'b0;
    repeat (100) tick();
    rx_pin = 1'b1;
    repeat (2 * CYCLE) tick();
    check(rx_data_valid == 1'b0, "glitch_no_valid", rx_data_valid, 0);
    check_counts("glitch");
    issue(8'h3C, CYCLE, 1'b1);
    wait_drain(2 * CYCLE, "after_glitch_drain");

    // Framing error followed by a 20-bit break, then a good frame.
    issue(8'h81, CYCLE, 1'b0);
    rx_pin = 1'b0;
    repeat (20 * CYCLE) tick();
    rx_pin = 1'b1;
    repeat (CYCLE) tick();
    check_counts("frame_err");
    issue(8'h42, CYCLE, 1'b1);
    wait_drain(2 * CYCLE, "after_break_drain");
    check_counts("after_break");

    // Overrun: second byte arrives while the first is still unaccepted.
    rx_data_ready = 1'b0;
    issue(8'h11, CYCLE, 1'b1);
    send_frame(8'h22, CYCLE, 1'b1);
    ov_exp++;
    check_counts("overrun");
    check(rx_data == 8'h11, "overrun_data_kept", rx_data, 8'h11);
    check(rx_data_valid == 1'b1, "overrun_valid_kept", rx_data_valid, 1);

    // Reset in the middle of data bit 4 of a frame.
    pat    = 8'hF0;
    rx_pin = 1'b0;
    repeat (CYCLE) tick();
    for (int i = 0; i < 4; i++) begin
      rx_pin = pat[i];
      repeat (CYCLE) tick();
    end
    rx_pin = pat[4];
    repeat (HALF) tick();
    rst = 1'b1;
    #1;
    exp_q.delete();
    check(rx_data == 8'h00, "midframe_reset_data", rx_data, 0);
    check(rx_data_valid == 1'b0, "midframe_reset_valid", rx_data_valid, 0);
    check(rx_frame_err == 1'b0, "midframe_reset_frame_err", rx_frame_err, 0);
    check(rx_overrun == 1'b0, "midframe_reset_overrun", rx_overrun, 0);
    rx_pin = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (CYCLE) tick();
    rx_data_ready = 1'b1;
    issue(8'h96, CYCLE * 102 / 100, 1'b1);
    wait_drain(2 * CYCLE, "baud_plus2_drain");
    issue(8'h96, CYCLE * 98 / 100, 1'b1);
    wait_drain(2 * CYCLE, "baud_minus2_drain");
    check_counts("baud_tol");

    // Random bytes, small baud jitter, occasional bad stop bits, ready stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          b      = 8'($urandom);
          ok     = ($urandom_range(0, 3) != 0);
          period = CYCLE - 4 + int'($urandom_range(0, 8));
          issue(b, period, ok);
          gap = ok ? int'($urandom_range(0, HALF)) : CYCLE + int'($urandom_range(0, HALF));
          repeat (gap) tick();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rx_data_ready = 1'b1;
          repeat ($urandom_range(1, 300)) tick();
          rx_data_ready = 1'b0;
          repeat ($urandom_range(1, 800)) tick();
        end
        rx_data_ready = 1'b1;
      end
    join
    wait_drain(2 * CYCLE, "random_drain");
    check_counts("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
